// File: rtl/psum_col_fifo_pkg.sv
// psum_col_fifo_pkg: shared sizes and lane word type
// for the MAC-array output FIFO.
package psum_col_fifo_pkg;

  localparam int PSUM_BW     = 16;
  localparam int COL         = 8;
  localparam int OFIFO_DEPTH = 64;
  localparam int OFIFO_AW    = $clog2(OFIFO_DEPTH);

  typedef logic [PSUM_BW-1:0] psum_t;

endpackage

// File: rtl/psum_lane_fifo.sv
// psum_lane_fifo: one column lane, circular buffer
// with wrap-bit pointers and pop-override on write.
module psum_lane_fifo
  import psum_col_fifo_pkg::*;
#(
  parameter int depth   = OFIFO_DEPTH,
  parameter int aw      = OFIFO_AW,
  parameter int psum_bw = PSUM_BW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr,
  input  logic [psum_bw-1:0] din,
  input  logic               pop,
  output logic [psum_bw-1:0] dout,
  output logic               full,
  output logic               empty
);

  logic [psum_bw-1:0] mem [depth];
  logic [aw:0]        wptr;
  logic [aw:0]        rptr;
  logic               wr_acc;

  assign empty  = (wptr == rptr);
  assign full   = (wptr[aw-1:0] == rptr[aw-1:0])
                & (wptr[aw] != rptr[aw]);
  // A full lane still takes a write when the head leaves.
  assign wr_acc = wr & (~full | pop);
  assign dout   = mem[rptr[aw-1:0]];

  // Pointer advance; wrap is natural modulo 2*depth.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_acc) wptr <= wptr + 1'b1;
      if (pop)    rptr <= rptr + 1'b1;
    end
  end

  // Storage write; contents are not reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wptr[aw-1:0]] <= din;
  end

endmodule

// File: rtl/psum_col_fifo.sv
// psum_col_fifo: per-column psum FIFO, pops whole rows.
// Optional sticky error flags under PSUM_FIFO_ERR_EN.
module psum_col_fifo
  import psum_col_fifo_pkg::*;
#(
  parameter int col     = COL,
  parameter int psum_bw = PSUM_BW,
  parameter int depth   = OFIFO_DEPTH,
  parameter int aw      = OFIFO_AW
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [col-1:0]         wr,
  input  logic [psum_bw*col-1:0] in,
  input  logic                   rd,
  output logic [psum_bw*col-1:0] out,
  output logic                   valid_out,
  output logic                   o_ready,
  output logic                   o_full,
  output logic                   o_empty
`ifdef PSUM_FIFO_ERR_EN
  ,
  output logic [col-1:0]         o_overflow,
  output logic                   o_underflow
`endif
);

  logic [col-1:0]         lane_full;
  logic [col-1:0]         lane_empty;
  logic [psum_bw*col-1:0] head;
  logic                   pop;

  assign o_ready = &(~lane_empty);
  assign o_full  = |lane_full;
  assign o_empty = &lane_empty;
  assign pop     = rd & o_ready;

  for (genvar k = 0; k < col; k++) begin : g_lane
    psum_lane_fifo #(
      .depth  (depth),
      .aw     (aw),
      .psum_bw(psum_bw)
    ) u_lane (
      .clk  (clk),
      .reset(reset),
      .wr   (wr[k]),
      .din  (in[psum_bw*k +: psum_bw]),
      .pop  (pop),
      .dout (head[psum_bw*k +: psum_bw]),
      .full (lane_full[k]),
      .empty(lane_empty[k])
    );
  end

  // Register the popped row; out holds between pops.
  always_ff @(posedge clk) begin
    if (reset) begin
      out       <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= pop;
      if (pop) out <= head;
    end
  end

`ifdef PSUM_FIFO_ERR_EN
  // Sticky drop/underflow flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_overflow  <= '0;
      o_underflow <= 1'b0;
    end else begin
      o_overflow  <= o_overflow
                   | (wr & lane_full & {col{~pop}});
      o_underflow <= o_underflow | (rd & ~o_ready);
    end
  end
`endif

endmodule

// File: doc/psum_col_fifo.md
Name: psum_col_fifo

Overview:
- Per-column output FIFO between the MAC array's bottom row and the SFP stage.
- Each array column writes partial sums independently.
- A full row (all `col` entries) is popped only when every column holds data. The popped row is presented as a registered vector with a one-cycle `valid_out` pulse, which drives the SFP's `valid_in`.

Parameters:
- col, 8, number of array columns / FIFO lanes
- psum_bw, 16, partial-sum width per lane
- depth, 64, entries per lane; must be a power of 2, ≥ 2
- aw, 6, log2(depth)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset; clock clk
- wr  in  col  per-lane write strobe from the array's bottom row
- in  in  psum_bw*col  per-lane write data; lane k at bits [psum_bw*(k+1)-1 : psum_bw*k]
- rd  in  1  row-pop request from the controller
- out  out  psum_bw*col  registered popped row, same lane packing as in
- valid_out  out  1  one-cycle pulse; out is valid (feeds SFP valid_in)
- o_ready  out  1  all lanes non-empty (a rd this cycle will pop)
- o_full  out  1  any lane full
- o_empty  out  1  all lanes empty

Behaviour:
- Reset:
  - All read/write pointers cleared.
  - out = 0, valid_out = 0, o_ready = 0, o_full = 0, o_empty = 1.
  - Lane storage contents are not reset. An in-flight pop is discarded.
- Each lane is a circular buffer with aw+1-bit read and write pointers, using the extra wrap bit.
  - Lane empty when the pointers are equal.
  - Lane full when the low aw bits are equal and the wrap bits differ.
- Write (lane k):
  - Accepted when wr[k] = 1 and the lane is not full, OR when the lane is full and a pop is accepted in the same cycle.
  - An accepted write stores in-lane data at wptr and increments wptr. Wrap-around is natural modulo 2*depth.
  - A write to a full lane with no simultaneous pop is dropped; the pointer is unchanged.
- Pop:
  - Accepted when rd = 1 and o_ready = 1. All lanes' rptr increment together.
  - Next cycle: out = the row at the old rptr of every lane, and valid_out = 1.
  - Read latency is 1 cycle from the accepting edge.
  - rd with o_ready = 0 is ignored: no pointer change, valid_out = 0 next cycle.
- out holds its last value when no pop occurs. valid_out is 0 in every cycle not following an accepted pop.
- Back-to-back pops are allowed every cycle while o_ready holds, giving 1 row/cycle throughput.
- Simultaneous write and pop on a non-full lane: both take effect and occupancy is unchanged.
- Simultaneous write and pop on an empty lane: the pop cannot be accepted because o_ready = 0, so only the write occurs.
- Status outputs:
  - o_ready, o_full and o_empty are combinational from the current pointers. They reflect state after the last clock edge, not same-cycle strobes.
- Lanes fill skewed, as the array drains diagonally. Rows are still popped in order, so lane k's n-th entry is always paired with every other lane's n-th entry.

Optional Feature:
- Macro: PSUM_FIFO_ERR_EN.
- Defined:
  - Adds output o_overflow [col]: per-lane sticky bit, set when a write is dropped at full.
  - Adds output o_underflow [1]: sticky bit, set when rd = 1 while o_ready = 0.
  - Both flags are cleared only by reset. A flag sets the cycle after the event.
- Undefined:
  - Neither port exists and no flag logic is generated.
  - Dropped writes and ignored reads behave identically to the defined case.

Decomposition:
- Shared package holds:
  - PSUM_BW = 16, COL = 8, OFIFO_DEPTH = 64 and its log2.
  - A typedef for one psum lane word.
- Natural sub-module `psum_lane_fifo` (one lane):
  - Ports: storage, pointers, full/empty, write accept with pop-override, and head-data output.
  - Instantiated `col` times via generate.
- The top level does:
  - AND-reduce of lane non-empty into o_ready.
  - Common pop strobe to all lanes.
  - Output register and valid_out.

Test Plan:
- Reset then idle: o_empty=1, o_ready=0, valid_out=0, out=0 for 10 cycles; rd=1 in that window gives no valid_out (o_underflow=1 if enabled).
- Skewed fill: lane k gets value 100+k written at cycle k (k=0..7); o_ready rises only after lane 7's write; rd gives out lanes = 100..107 and valid_out=1 exactly one cycle later.
- Fill to full: write 64 values 0..63 into all lanes, then o_full=1; a 65th write of 999 is dropped (o_overflow=0xFF if enabled); 64 pops return 0..63 in order, then o_empty=1.
- Full lanes with wr=all and rd together: pop returns the oldest row, the new row is accepted, o_full stays 1, no overflow flag.
- Streaming: continuous wr and rd for 200 cycles with pointer wrap; output sequence equals input sequence, valid_out high every cycle after the first.
- Reset mid-stream with 10 rows queued and a pop in flight: valid_out=0 the next cycle, o_empty=1, and a subsequent single write+pop returns only the new data.
